// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of a single-ported RAM bus.
//   A data port (read/write) and an instruction port (read only) compete for
//   one shared bus. One transaction runs at a time: IDLE picks a winner, BUS
//   holds the request until the slave acks, DONE pulses the winner's ack.
//   Every output is registered.
//
// Build option:
//   RAM_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                           between the ports (instruction wins the first
//                           tie after reset). When undefined, the data port
//                           always wins a tie.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   d_req_i/d_we_i/d_addr_i/d_data_i   data-port request side
//   d_data_o/d_ack_o                   data-port read data, completion pulse
//   i_req_i/i_addr_i                   instruction-port request side
//   i_data_o/i_ack_o                   instruction-port read data, completion pulse
//   bus_addr_o/bus_data_o/bus_select_o/bus_we_o   shared bus request
//   bus_data_i/bus_ack_i                          shared bus response
//   grant_o           current owner, bit0 data, bit1 instruction, 00 when idle
//
// state | meaning
// IDLE  | no transaction; sample requests and pick a winner
// BUS   | bus request presented and held until bus_ack_i
// DONE  | winner's ack pulsed for one cycle, then back to IDLE
module ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_data_i,
  output logic [DW-1:0] d_data_o,
  output logic          d_ack_o,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic [DW-1:0] i_data_o,
  output logic          i_ack_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_data_o,
  output logic          bus_select_o,
  output logic          bus_we_o,
  input  logic [DW-1:0] bus_data_i,
  input  logic          bus_ack_i,
  output logic [1:0]    grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    grant_nxt;
  logic [AW-1:0] bus_addr_nxt;
  logic [DW-1:0] bus_data_nxt;
  logic          bus_select_nxt;
  logic          bus_we_nxt;
  logic [DW-1:0] d_data_nxt;
  logic [DW-1:0] i_data_nxt;
  logic          d_ack_nxt;
  logic          i_ack_nxt;
  logic          pick_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // 1 = data port was granted most recently
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (d_req_i || i_req_i)) begin
      last_d <= pick_d;
    end
  end

  assign pick_d = d_req_i && (!i_req_i || !last_d);
`else
  assign pick_d = d_req_i;
`endif

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_o;
    bus_addr_nxt   = bus_addr_o;
    bus_data_nxt   = bus_data_o;
    bus_select_nxt = bus_select_o;
    bus_we_nxt     = bus_we_o;
    d_data_nxt     = d_data_o;
    i_data_nxt     = i_data_o;
    d_ack_nxt      = 1'b0;
    i_ack_nxt      = 1'b0;

    case (state)
      IDLE: begin
        grant_nxt = 2'b00;
        if (d_req_i || i_req_i) begin
          state_nxt      = BUS;
          bus_select_nxt = 1'b1;
          if (pick_d) begin
            grant_nxt    = 2'b01;
            bus_addr_nxt = d_addr_i;
            bus_data_nxt = d_data_i;
            bus_we_nxt   = d_we_i;
          end else begin
            // instruction fetch leaves bus_data_o at its previous value
            grant_nxt    = 2'b10;
            bus_addr_nxt = i_addr_i;
            bus_we_nxt   = 1'b0;
          end
        end
      end
      BUS: begin
        if (bus_ack_i) begin
          state_nxt      = DONE;
          bus_select_nxt = 1'b0;
          bus_we_nxt     = 1'b0;
          // writes capture bus_data_i too, keeping both ports uniform
          if (grant_o[0]) begin
            d_data_nxt = bus_data_i;
            d_ack_nxt  = 1'b1;
          end else begin
            i_data_nxt = bus_data_i;
            i_ack_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
      default: begin
        state_nxt      = IDLE;
        grant_nxt      = 2'b00;
        bus_select_nxt = 1'b0;
        bus_we_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_o      <= '0;
      bus_addr_o   <= '0;
      bus_data_o   <= '0;
      bus_select_o <= 1'b0;
      bus_we_o     <= 1'b0;
      d_data_o     <= '0;
      i_data_o     <= '0;
      d_ack_o      <= 1'b0;
      i_ack_o      <= 1'b0;
    end else begin
      grant_o      <= grant_nxt;
      bus_addr_o   <= bus_addr_nxt;
      bus_data_o   <= bus_data_nxt;
      bus_select_o <= bus_select_nxt;
      bus_we_o     <= bus_we_nxt;
      d_data_o     <= d_data_nxt;
      i_data_o     <= i_data_nxt;
      d_ack_o      <= d_ack_nxt;
      i_ack_o      <= i_ack_nxt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter (default 32-bit widths).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_data_i, d_data_o;
  logic        d_ack_o;
  logic        i_req_i;
  logic [31:0] i_addr_i, i_data_o;
  logic        i_ack_o;
  logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
  logic        bus_select_o, bus_we_o, bus_ack_i;
  logic [1:0]  grant_o;

  int n_vec = 0;
  int n_err = 0;

  ram_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i),
    .i_data_o(i_data_o), .i_ack_o(i_ack_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_select_o(bus_select_o), .bus_we_o(bus_we_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, " grant"},  grant_o, 2'b00);
    check_vec({tag, " sel"},    bus_select_o, 1'b0);
    check_vec({tag, " we"},     bus_we_o, 1'b0);
    check_vec({tag, " addr"},   bus_addr_o, 32'h0);
    check_vec({tag, " wdata"},  bus_data_o, 32'h0);
    check_vec({tag, " d_ack"},  d_ack_o, 1'b0);
    check_vec({tag, " i_ack"},  i_ack_o, 1'b0);
    check_vec({tag, " d_data"}, d_data_o, 32'h0);
    check_vec({tag, " i_data"}, i_data_o, 32'h0);
  endtask

  initial begin
    logic [1:0] exp_g;
    rst = 1'b1;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_data_i = 0;
    i_req_i = 0; i_addr_i = 0;
    bus_data_i = 0; bus_ack_i = 0;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // zero-wait instruction read; ack already high in IDLE must be ignored
    i_req_i = 1; i_addr_i = 32'h40; bus_ack_i = 1; bus_data_i = 32'h3C011234;
    step();
    check_vec("zw bus sel", bus_select_o, 1'b1);
    check_vec("zw bus addr", bus_addr_o, 32'h40);
    check_vec("zw bus we", bus_we_o, 1'b0);
    check_vec("zw grant", grant_o, 2'b10);
    check_vec("zw i_ack early", i_ack_o, 1'b0);
    step();
    check_vec("zw sel drop", bus_select_o, 1'b0);
    check_vec("zw i_ack", i_ack_o, 1'b1);
    check_vec("zw d_ack", d_ack_o, 1'b0);
    check_vec("zw i_data", i_data_o, 32'h3C011234);
    check_vec("zw grant done", grant_o, 2'b10);
    i_req_i = 0; bus_ack_i = 0;
    step();
    check_vec("zw i_ack once", i_ack_o, 1'b0);
    check_vec("zw grant idle", grant_o, 2'b00);
    check_vec("zw sel idle", bus_select_o, 1'b0);

    // wait-state data write, slave acks at end of third BUS cycle
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_data_i = 32'hDEADBEEF;
    bus_data_i = 32'h11112222;
    for (int k = 0; k < 3; k++) begin
      step();
      check_vec("ws sel", bus_select_o, 1'b1);
      check_vec("ws we", bus_we_o, 1'b1);
      check_vec("ws addr", bus_addr_o, 32'h100);
      check_vec("ws wdata", bus_data_o, 32'hDEADBEEF);
      check_vec("ws grant", grant_o, 2'b01);
      check_vec("ws d_ack early", d_ack_o, 1'b0);
    end
    bus_ack_i = 1;
    step();
    check_vec("ws d_ack", d_ack_o, 1'b1);
    check_vec("ws i_ack", i_ack_o, 1'b0);
    check_vec("ws we drop", bus_we_o, 1'b0);
    check_vec("ws sel drop", bus_select_o, 1'b0);
    check_vec("ws d_data", d_data_o, 32'h11112222);
    check_vec("ws i_data hold", i_data_o, 32'h3C011234);
    d_req_i = 0; d_we_i = 0; bus_ack_i = 0;
    step();
    check_vec("ws d_ack once", d_ack_o, 1'b0);

    // tie with both requests held; fresh reset so the RR pointer is known
    rst = 1; step(); rst = 0; step();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h10; i_req_i = 1; i_addr_i = 32'h20;
    bus_ack_i = 1; bus_data_i = 32'h77;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      step();
      check_vec("tie grant", grant_o, exp_g);
      check_vec("tie sel", bus_select_o, 1'b1);
      step();
      check_vec("tie done sel", bus_select_o, 1'b0);
      check_vec("tie d_ack", d_ack_o, exp_g[0]);
      check_vec("tie i_ack", i_ack_o, exp_g[1]);
      step();
      check_vec("tie idle sel", bus_select_o, 1'b0);
      check_vec("tie idle grant", grant_o, 2'b00);
    end
    d_req_i = 0; i_req_i = 0; bus_ack_i = 0;
    step(); step();

    // reset during second BUS cycle with ack present: transaction abandoned
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_data_i = 32'hCAFEF00D;
    bus_data_i = 32'h99;
    step();
    check_vec("rst bus sel", bus_select_o, 1'b1);
    step();
    check_vec("rst bus sel2", bus_select_o, 1'b1);
    rst = 1; bus_ack_i = 1;
    step();
    check_all_zero("rst mid");
    rst = 0; d_req_i = 0; d_we_i = 0; bus_ack_i = 0;
    step();
    check_vec("rst no ack", d_ack_o, 1'b0);
    check_vec("rst idle sel", bus_select_o, 1'b0);

    // late instruction arrival during a data read
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300; bus_data_i = 32'hA5A5A5A5;
    step();
    check_vec("late grant d", grant_o, 2'b01);
    i_req_i = 1; i_addr_i = 32'h44;
    step();
    check_vec("late still d", grant_o, 2'b01);
    check_vec("late addr d", bus_addr_o, 32'h300);
    bus_ack_i = 1;
    step();
    check_vec("late d_ack", d_ack_o, 1'b1);
    check_vec("late d_data", d_data_o, 32'hA5A5A5A5);
    check_vec("late gap1 sel", bus_select_o, 1'b0);
    d_req_i = 0; bus_ack_i = 0;
    step();
    check_vec("late gap2 sel", bus_select_o, 1'b0);
    check_vec("late gap2 grant", grant_o, 2'b00);
    check_vec("late gap2 i_ack", i_ack_o, 1'b0);
    step();
    check_vec("late i sel", bus_select_o, 1'b1);
    check_vec("late i grant", grant_o, 2'b10);
    check_vec("late i addr", bus_addr_o, 32'h44);
    // requester drops mid-BUS: transaction still completes
    i_req_i = 0; bus_ack_i = 1; bus_data_i = 32'h55;
    step();
    check_vec("drop i_ack", i_ack_o, 1'b1);
    check_vec("drop i_data", i_data_o, 32'h55);
    check_vec("drop d_data hold", d_data_o, 32'hA5A5A5A5);
    bus_ack_i = 0;
    step();
    check_vec("drop idle i_ack", i_ack_o, 1'b0);
    step();
    check_vec("drop stays idle", bus_select_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
